integral_window_gen: RTL
========================

INTEGRAL_WINDOW_GEN -- requirements
Module: integral_window_gen

Interface
REQ-001 Parameter W_PIX, default 8, input pixel width.
REQ-002 Parameter W_DATA, default 18, integral value width.
REQ-003 Parameter WINDOW_WIDTH, default 24, window columns.
REQ-004 Parameter WINDOW_HEIGHT, default 24, window rows.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 din_valid  input  1  pixel valid.
REQ-008 din_ready  output  1  pixel accepted when din_valid & din_ready.
REQ-009 din_data  input  W_PIX  unsigned pixel, raster order, one window per frame.
REQ-010 dout_valid  output  1  integral value valid.
REQ-011 dout_ready  input  1  downstream window buffer ready.
REQ-012 dout_data  output  W_DATA  integral value II(x,y).
REQ-013 dout_eot  output  2  bit0 = last column of row, bit1 = last value of window.

Function
REQ-014 II(x,y) = sum of all pixels at columns <= x and rows <= y of current window; dout_data SHALL equal II(x,y) for each accepted pixel, same order.
REQ-015 Computation: II(x,y) = rowsum(x,y) + II(x,y-1); rowsum cleared at column 0; II(x,-1) = 0 for row 0.
REQ-016 Previous-row II values held in a WINDOW_WIDTH x W_DATA line buffer, read then overwritten at column x in the same accepted cycle.
REQ-017 Latency: accepted pixel appears on dout one cycle later (single output register); throughput one value per cycle without backpressure.
REQ-018 din_ready = !dout_valid | dout_ready; pipeline stalls fully, no value lost or duplicated under backpressure.
REQ-019 dout_valid, dout_data, dout_eot SHALL hold stable while dout_valid & !dout_ready.
REQ-020 Column counter 0..WINDOW_WIDTH-1, row counter 0..WINDOW_HEIGHT-1, advance only on accepted pixel; column wraps to 0 and row increments at last column.
REQ-021 dout_eot[0] = 1 on column WINDOW_WIDTH-1; dout_eot[1] = 1 only on (WINDOW_WIDTH-1, WINDOW_HEIGHT-1), where dout_eot = 2'b11.
REQ-022 After last pixel of window both counters wrap to 0; next pixel starts a new window with row-0 behaviour (line buffer contents ignored), no idle cycle required.
REQ-023 Arithmetic unsigned, W_DATA wide; W_DATA SHALL be >= W_PIX + clog2(WINDOW_WIDTH*WINDOW_HEIGHT); no saturation.
REQ-024 Simultaneous output consumed and new input accepted in the same cycle SHALL be supported.

Reset
REQ-025 On rst low: dout_valid = 0, dout_eot = 0, dout_data = 0, counters = 0, rowsum = 0, immediately (asynchronous).
REQ-026 din_ready SHALL be 1 in first cycle after reset release.
REQ-027 Reset mid-window discards partial window; next accepted pixel is (0,0).
REQ-028 Line buffer contents need no reset (row 0 masks them).

Structure
REQ-029 W_PIX, W_DATA, WINDOW_WIDTH, WINDOW_HEIGHT defaults and eot bit indices SHALL live in shared package cascade_pkg.
REQ-030 Line buffer SHALL be sub-module ii_line_buffer (synchronous-read-free, combinational read, single write port, depth WINDOW_WIDTH).

Verification
REQ-031 576 pixels of 1, dout_ready=1 -> dout_data(x,y) = (x+1)*(y+1); last = 576 with eot=2'b11; eot[0] on every 24th value.
REQ-032 576 pixels of 255 -> last dout_data = 146880, no overflow; value at (23,0) = 6120.
REQ-033 Pixel = x+y ramp with random dout_ready (50%) and random din_valid -> output sequence matches golden model, no loss/duplication, dout stable while stalled.
REQ-034 Two back-to-back windows (all 1s then all 2s) -> second window (0,0) = 2, last = 1152; no leakage of first window.
REQ-035 Assert rst low after 100 pixels, release, send full window of 1s -> dout_valid=0 during reset, first output 1 at (0,0), last 576 with eot=2'b11.

Source files
------------

// File: rtl/cascade_pkg.sv
// Shared defaults and end-of-transfer flag layout for the integral-image cascade.
// Imported by the integral window generator and its line buffer.
package cascade_pkg;

  localparam int W_PIX_DEF         = 8;
  localparam int W_DATA_DEF        = 18;
  localparam int WINDOW_WIDTH_DEF  = 24;
  localparam int WINDOW_HEIGHT_DEF = 24;

  localparam int EOT_W       = 2;
  localparam int EOT_ROW_BIT = 0;
  localparam int EOT_WIN_BIT = 1;

  // Window-last implies row-last, so the window flag is only raised with the row flag.
  function automatic logic [EOT_W-1:0] make_eot(input logic last_col, input logic last_row);
    logic [EOT_W-1:0] e;
    e              = '0;
    e[EOT_ROW_BIT] = last_col;
    e[EOT_WIN_BIT] = last_col & last_row;
    return e;
  endfunction

endpackage

// File: rtl/ii_line_buffer.sv
// Previous-row integral values, one entry per window column.
// Combinational read and a single write port on the same address, so a column is read then replaced.
module ii_line_buffer
  import cascade_pkg::*;
#(
  parameter int W_DATA = W_DATA_DEF,
  parameter int DEPTH  = WINDOW_WIDTH_DEF,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [W_DATA-1:0] wr_data_i,
  output logic [W_DATA-1:0] rd_data_o
);

  // Contents are never reset: row 0 ignores whatever is stored here.
  logic [W_DATA-1:0] mem_q [DEPTH];

  assign rd_data_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/integral_window_gen.sv
// Streams the integral image of a raster-ordered window, one value per accepted pixel.
// II(x,y) = running row sum + II(x,y-1); a single output register gives one cycle latency.
module integral_window_gen
  import cascade_pkg::*;
#(
  parameter int W_PIX         = W_PIX_DEF,
  parameter int W_DATA        = W_DATA_DEF,
  parameter int WINDOW_WIDTH  = WINDOW_WIDTH_DEF,
  parameter int WINDOW_HEIGHT = WINDOW_HEIGHT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [W_PIX-1:0]  din_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [W_DATA-1:0] dout_data,
  output logic [EOT_W-1:0]  dout_eot
);

  localparam int COL_W = (WINDOW_WIDTH  > 1) ? $clog2(WINDOW_WIDTH)  : 1;
  localparam int ROW_W = (WINDOW_HEIGHT > 1) ? $clog2(WINDOW_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WINDOW_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(WINDOW_HEIGHT - 1);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [W_DATA-1:0] rowsum_q, rowsum_d;
  logic              dout_valid_q, dout_valid_d;
  logic [W_DATA-1:0] dout_data_q, dout_data_d;
  logic [EOT_W-1:0]  dout_eot_q, dout_eot_d;

  logic              accept;
  logic              last_col, last_row;
  logic [W_DATA-1:0] pix_ext;
  logic [W_DATA-1:0] rowsum_new;
  logic [W_DATA-1:0] above;
  logic [W_DATA-1:0] ii;
  logic [W_DATA-1:0] lb_rd;

  // The output register is the only storage stage, so it can refill whenever it drains.
  assign din_ready = !dout_valid_q | dout_ready;
  assign accept    = din_valid & din_ready;

  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);
  assign pix_ext  = W_DATA'(din_data);

  assign rowsum_new = ((col_q == '0) ? '0 : rowsum_q) + pix_ext;
  assign above      = (row_q == '0) ? '0 : lb_rd;
  assign ii         = rowsum_new + above;

  ii_line_buffer #(
    .W_DATA (W_DATA),
    .DEPTH  (WINDOW_WIDTH),
    .AW     (COL_W)
  ) u_line_buffer (
    .clk       (clk),
    .wr_en_i   (accept),
    .addr_i    (col_q),
    .wr_data_i (ii),
    .rd_data_o (lb_rd)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    rowsum_d     = rowsum_q;
    dout_valid_d = dout_valid_q;
    dout_data_d  = dout_data_q;
    dout_eot_d   = dout_eot_q;

    if (accept) begin
      rowsum_d     = rowsum_new;
      dout_valid_d = 1'b1;
      dout_data_d  = ii;
      dout_eot_d   = make_eot(last_col, last_row);
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      rowsum_q     <= '0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      dout_eot_q   <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      rowsum_q     <= rowsum_d;
      dout_valid_q <= dout_valid_d;
      dout_data_q  <= dout_data_d;
      dout_eot_q   <= dout_eot_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_data  = dout_data_q;
  assign dout_eot   = dout_eot_q;

endmodule
